// File: rtl/gp_imem_pkg.sv
// Shared types and boot image for the GP instruction memory.
// The boot table holds the start-up program copied into RAM after every reset or reload.
package gp_imem_pkg;

  localparam int          BOOT_WORDS_DEF = 42;
  localparam logic [31:0] NOP_WORD_DEF   = 32'h0000_0000;

  localparam logic [31:0] BOOT_TABLE [BOOT_WORDS_DEF] = '{
    32'h3c1d1000, 32'h37bd0ff0, 32'h3c080000, 32'h25080100,
    32'h3c090000, 32'h25290200, 32'h240a0010, 32'h8d0b0000,
    32'had2b0000, 32'h25080004, 32'h25290004, 32'h254affff,
    32'h1540fffa, 32'h00000000, 32'h3c0c2000, 32'h358c0001,
    32'had8c0000, 32'h240d0000, 32'h240e0040, 32'h25ad0001,
    32'h15aefffe, 32'h00000000, 32'h8d8f0004, 32'h31ef0001,
    32'h11e0fffc, 32'h00000000, 32'h3c100000, 32'h26100300,
    32'h02000008, 32'h00000000, 32'h0bf00000, 32'h00000000,
    32'h24020001, 32'h24030002, 32'h00431020, 32'hac020000,
    32'h1000ffff, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000
  };

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } gp_state_e;

endpackage

// File: rtl/gp_imem_boot_rom.sv
// Combinational boot-image lookup: index -> instruction word.
// Indices past the image (or past the table) return the NOP word.
import gp_imem_pkg::*;

module gp_imem_boot_rom #(
  parameter int                DATA_W     = 32,
  parameter int                IDX_W      = 6,
  parameter int                BOOT_WORDS = BOOT_WORDS_DEF,
  parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(NOP_WORD_DEF)
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] word
);

  always_comb begin
    word = NOP_WORD;
    if ((32'(idx) < BOOT_WORDS) && (32'(idx) < BOOT_WORDS_DEF))
      word = DATA_W'(BOOT_TABLE[idx]);
  end

endmodule

// File: rtl/gp_imem.sv
// Writable GP instruction memory: self-loads the boot image, then serves fetches and host writes.
// Optional GP_IMEM_PARITY_EN adds a stored even-parity bit per word with read-side checking.
import gp_imem_pkg::*;

module gp_imem #(
  parameter int                ADDR_W     = 30,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 64,
  parameter int                BOOT_WORDS = BOOT_WORDS_DEF,
  parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              stall,
  output logic [DATA_W-1:0] inst,
  output logic              ready,
  input  logic              reload,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              par_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef GP_IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  gp_state_e         state_q, state_d;
  logic [IDX_W-1:0]  boot_idx_q, boot_idx_d;
  logic [ADDR_W-1:0] addr_r;
  logic              wr_ack_q, wr_err_q;

  logic [MEM_W-1:0]  mem [DEPTH];

  logic [DATA_W-1:0] boot_word;
  logic              boot_we, wr_accept, wr_in_range, rd_in_range, rd_bad;
  logic [MEM_W-1:0]  boot_row, wr_row, rd_row;

  gp_imem_boot_rom #(
    .DATA_W     (DATA_W),
    .IDX_W      (IDX_W),
    .BOOT_WORDS (BOOT_WORDS),
    .NOP_WORD   (NOP_WORD)
  ) u_boot_rom (
    .idx  (boot_idx_q),
    .word (boot_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      boot_idx_q <= '0;
      addr_r     <= '0;
      wr_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_idx_q <= boot_idx_d;
      if (!stall) addr_r <= addr;
      wr_ack_q   <= wr_accept;
      wr_err_q   <= wr_accept && !wr_in_range;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_idx_d = boot_idx_q;
    boot_we    = 1'b0;
    wr_accept  = 1'b0;
    case (state_q)
      BOOT: begin
        boot_we    = 1'b1;
        boot_idx_d = boot_idx_q + IDX_W'(1);
        if (boot_idx_q == IDX_W'(BOOT_WORDS - 1)) begin
          state_d    = RUN;
          boot_idx_d = '0;
        end
      end
      RUN: begin
        if (reload) begin
          state_d    = BOOT;
          boot_idx_d = '0;
        end else begin
          wr_accept = wr_en;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Range checks use the full address so aliased high addresses never hit RAM.
  assign wr_in_range = (wr_addr < ADDR_W'(DEPTH));
  assign rd_in_range = (addr_r  < ADDR_W'(DEPTH));

`ifdef GP_IMEM_PARITY_EN
  assign boot_row = {^boot_word, boot_word};
  assign wr_row   = {^wr_data, wr_data};
`else
  assign boot_row = boot_word;
  assign wr_row   = wr_data;
`endif

  always_ff @(posedge clk) begin
    if (boot_we)
      mem[boot_idx_q] <= boot_row;
    else if (wr_accept && wr_in_range)
      mem[wr_addr[IDX_W-1:0]] <= wr_row;
  end

  assign rd_row = mem[addr_r[IDX_W-1:0]];
  assign ready  = (state_q == RUN);

`ifdef GP_IMEM_PARITY_EN
  assign rd_bad = ready && rd_in_range && (^rd_row);
`else
  assign rd_bad = 1'b0;
`endif

  assign inst    = (ready && rd_in_range && !rd_bad) ? rd_row[DATA_W-1:0] : NOP_WORD;
  assign par_err = rd_bad;
  assign wr_ack  = wr_ack_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_gp_imem.sv
// Directed self-checking bench for gp_imem: boot, fetch, host writes, stall, reload and reset.
`timescale 1ns/1ps

module tb_gp_imem;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] addr;
  logic        stall;
  logic [31:0] inst;
  logic        ready;
  logic        reload;
  logic        wr_en;
  logic [29:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        wr_err;
  logic        par_err;

  int n_cmp = 0;
  int n_bad = 0;

  gp_imem dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .stall   (stall),
    .inst    (inst),
    .ready   (ready),
    .reload  (reload),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_ack  (wr_ack),
    .wr_err  (wr_err),
    .par_err (par_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits out a boot copy: ready must stay low for 41 more edges, then rise on the 42nd.
  task automatic check_boot_window(input string tag);
    int early = 0;
    for (int i = 1; i <= 41; i++) begin
      step();
      n_cmp++;
      if (ready !== 1'b0 || inst !== 32'h0) begin
        n_bad++;
        early++;
        if (early <= 3)
          $display("FAIL %s_boot_low edge=%0d ready=%b inst=%h required ready=0 inst=0", tag, i, ready, inst);
      end
    end
    step();
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready_rise ready=%b required 1", tag, ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; addr = '0; stall = 1'b0; reload = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (ready !== 1'b0 || inst !== 32'h0 || wr_ack !== 1'b0 || wr_err !== 1'b0 || par_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values ready=%b inst=%h ack=%b err=%b par=%b required all 0",
               ready, inst, wr_ack, wr_err, par_err);
    end
    @(negedge clk);
    rst = 1'b1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_ready ready=%b required 0", ready);
    end
  endtask

  task automatic test_boot();
    check_boot_window("init");
    n_cmp++;
    if (inst !== 32'h3c1d1000) begin
      n_bad++;
      $display("FAIL boot_word0 inst=%h required 3c1d1000", inst);
    end
    addr = 30'd5;
    step();
    n_cmp++;
    if (inst !== 32'h25290200) begin
      n_bad++;
      $display("FAIL boot_word5 inst=%h required 25290200", inst);
    end
    addr = 30'd41;
    step();
    n_cmp++;
    if (inst !== 32'h00000000) begin
      n_bad++;
      $display("FAIL boot_word41 inst=%h required 00000000", inst);
    end
  endtask

  task automatic test_write();
    addr = 30'd5; wr_en = 1'b1; wr_addr = 30'd5; wr_data = 32'hdeadbeef;
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin
      n_bad++;
      $display("FAIL write_ack ack=%b err=%b required ack=1 err=0", wr_ack, wr_err);
    end
    n_cmp++;
    if (inst !== 32'hdeadbeef) begin
      n_bad++;
      $display("FAIL write_first inst=%h required deadbeef", inst);
    end
    step();
    n_cmp++;
    if (wr_ack !== 1'b0 || inst !== 32'hdeadbeef) begin
      n_bad++;
      $display("FAIL write_ack_pulse ack=%b inst=%h required ack=0 inst=deadbeef", wr_ack, inst);
    end
    wr_en = 1'b1; wr_addr = 30'd63; wr_data = 32'hcafef00d; addr = 30'd63;
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b0 || inst !== 32'hcafef00d) begin
      n_bad++;
      $display("FAIL write_last_word ack=%b err=%b inst=%h required 1 0 cafef00d", wr_ack, wr_err, inst);
    end
  endtask

  task automatic test_out_of_range();
    addr = 30'd64;
    step();
    n_cmp++;
    if (inst !== 32'h0) begin
      n_bad++;
      $display("FAIL fetch_oor64 inst=%h required 0", inst);
    end
    addr = 30'h2000_0005;
    step();
    n_cmp++;
    if (inst !== 32'h0) begin
      n_bad++;
      $display("FAIL fetch_oor_high inst=%h required 0", inst);
    end
    wr_en = 1'b1; wr_addr = 30'd100; wr_data = 32'h12345678; addr = 30'd36;
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b1) begin
      n_bad++;
      $display("FAIL write_oor100 ack=%b err=%b required 1 1", wr_ack, wr_err);
    end
    n_cmp++;
    if (inst !== 32'h1000ffff) begin
      n_bad++;
      $display("FAIL oor_alias_untouched inst=%h required 1000ffff", inst);
    end
    wr_en = 1'b1; wr_addr = 30'd64; wr_data = 32'h87654321; addr = 30'd0;
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (wr_ack !== 1'b1 || wr_err !== 1'b1 || inst !== 32'h3c1d1000) begin
      n_bad++;
      $display("FAIL write_oor64 ack=%b err=%b inst=%h required 1 1 3c1d1000", wr_ack, wr_err, inst);
    end
    step();
    n_cmp++;
    if (wr_ack !== 1'b0 || wr_err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_pulse ack=%b err=%b required 0 0", wr_ack, wr_err);
    end
  endtask

  task automatic test_stall();
    addr = 30'd5;
    step();
    stall = 1'b1; addr = 30'd0;
    step();
    n_cmp++;
    if (inst !== 32'hdeadbeef) begin
      n_bad++;
      $display("FAIL stall_hold inst=%h required deadbeef", inst);
    end
    addr = 30'd3;
    step();
    n_cmp++;
    if (inst !== 32'hdeadbeef) begin
      n_bad++;
      $display("FAIL stall_hold2 inst=%h required deadbeef", inst);
    end
    stall = 1'b0;
    step();
    n_cmp++;
    if (inst !== 32'h25080100) begin
      n_bad++;
      $display("FAIL stall_release inst=%h required 25080100", inst);
    end
  endtask

  task automatic test_reload();
    reload = 1'b1; wr_en = 1'b1; wr_addr = 30'd7; wr_data = 32'h11111111; addr = 30'd5;
    step();
    reload = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if (wr_ack !== 1'b0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reload_collision ack=%b ready=%b required 0 0", wr_ack, ready);
    end
    check_boot_window("reload");
    n_cmp++;
    if (inst !== 32'h25290200) begin
      n_bad++;
      $display("FAIL reload_word5 inst=%h required 25290200", inst);
    end
    addr = 30'd7;
    step();
    n_cmp++;
    if (inst !== 32'h8d0b0000) begin
      n_bad++;
      $display("FAIL reload_word7 inst=%h required 8d0b0000", inst);
    end
    n_cmp++;
    if (wr_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL reload_no_late_ack ack=%b required 0", wr_ack);
    end
  endtask

  task automatic test_mid_boot_reset();
    wr_en = 1'b1; wr_addr = 30'd5; wr_data = 32'h55aa55aa;
    step();
    wr_en = 1'b0;
    reload = 1'b1;
    step();
    reload = 1'b0;
    repeat (10) step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || inst !== 32'h0 || wr_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL midboot_reset ready=%b inst=%h ack=%b required 0 0 0", ready, inst, wr_ack);
    end
    addr = 30'd5;
    @(negedge clk);
    rst = 1'b1;
    check_boot_window("rstboot");
    n_cmp++;
    if (inst !== 32'h25290200) begin
      n_bad++;
      $display("FAIL rstboot_word5 inst=%h required 25290200", inst);
    end
  endtask

  task automatic test_parity();
    addr = 30'd3;
`ifdef GP_IMEM_PARITY_EN
    dut.mem[3][0] = ~dut.mem[3][0];
    step();
    n_cmp++;
    if (par_err !== 1'b1 || inst !== 32'h0) begin
      n_bad++;
      $display("FAIL parity_flip par=%b inst=%h required 1 0", par_err, inst);
    end
`else
    step();
    n_cmp++;
    if (par_err !== 1'b0 || inst !== 32'h25080100) begin
      n_bad++;
      $display("FAIL parity_off par=%b inst=%h required 0 25080100", par_err, inst);
    end
`endif
    addr = 30'd0;
    step();
    n_cmp++;
    if (par_err !== 1'b0 || inst !== 32'h3c1d1000) begin
      n_bad++;
      $display("FAIL parity_clean par=%b inst=%h required 0 3c1d1000", par_err, inst);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_write();
    test_out_of_range();
    test_stall();
    test_reload();
    test_mid_boot_reset();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
